// File: rtl/airi5c_uart_rx.sv
// AIRI5C UART receiver: synchronises rx, deframes start/data/parity/stop, queues
// received words in a small FIFO and drives the active-low rts flow-control line.
module airi5c_uart_rx #(
  parameter int STACK_ADDR_WIDTH = 5,
  parameter int RTS_MARGIN       = 2
) (
  input  logic                      clk,
  input  logic                      n_reset,
  input  logic                      clear,
  input  logic                      rx,
  output logic                      rts,
  input  logic [31:0]               ctrl_reg,
  input  logic                      pop,
  output logic [8:0]                data_out,
  output logic [STACK_ADDR_WIDTH:0] size,
  output logic                      empty,
  output logic                      full,
  output logic                      parity_error,
  output logic                      frame_error,
  output logic                      overflow_error
);

  localparam int DEPTH = 1 << STACK_ADDR_WIDTH;
  localparam logic [STACK_ADDR_WIDTH:0] DEPTH_W  = DEPTH[STACK_ADDR_WIDTH:0];
  localparam logic [STACK_ADDR_WIDTH:0] MARGIN_W = RTS_MARGIN[STACK_ADDR_WIDTH:0];
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } state_e;

  state_e state_q, state_d;
  logic        rx_meta_q, rx_sync_q;
  logic [23:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [8:0]  data_q, data_d;
  logic        par_bad_q, par_bad_d;
  logic        frm_bad_q, frm_bad_d;
  logic        push_q, push_d;
  logic        par_err_q, frm_err_q, ovf_err_q, rts_q;

  logic [STACK_ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [STACK_ADDR_WIDTH:0]   count_q;
  logic [8:0]                  mem_q [DEPTH];

  logic [23:0] baud_s, baud_m1_s, half_s;
  logic [3:0]  last_bit_s;
  logic [1:0]  parity_s;
  logic        flow_s, wr_en_s, rd_en_s, full_s, empty_s;
  logic [STACK_ADDR_WIDTH:0] free_s;
  logic        unused_stop_s;

  assign baud_s        = ctrl_reg[23:0];
  assign baud_m1_s     = baud_s - 24'd1;
  assign half_s        = {1'b0, baud_s[23:1]};
  assign last_bit_s    = {1'b0, ctrl_reg[31:29]} + 4'd4;
  assign parity_s      = ctrl_reg[28:27];
  assign flow_s        = ctrl_reg[24];
  // Only the first stop bit is ever sampled, so the stop-bit count needs no decoding.
  assign unused_stop_s = ^ctrl_reg[26:25];

  assign full_s   = (count_q == DEPTH_W);
  assign empty_s  = (count_q == {(STACK_ADDR_WIDTH+1){1'b0}});
  assign wr_en_s  = push_q & ~full_s & ~clear;
  assign rd_en_s  = pop & ~empty_s & ~clear;
  assign free_s   = DEPTH_W - count_q;

  assign size           = count_q;
  assign empty          = empty_s;
  assign full           = full_s;
  assign data_out       = empty_s ? 9'd0 : mem_q[rd_ptr_q];
  assign parity_error   = par_err_q;
  assign frame_error    = frm_err_q;
  assign overflow_error = ovf_err_q;
  assign rts            = rts_q;

  // Two-stage synchroniser; idle level is high.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 24'd0;
      bit_q     <= 4'd0;
      data_q    <= 9'd0;
      par_bad_q <= 1'b0;
      frm_bad_q <= 1'b0;
      push_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      par_bad_q <= par_bad_d;
      frm_bad_q <= frm_bad_d;
      push_q    <= push_d;
    end
  end

  // Comparisons use >= so a baud change mid-frame still terminates the frame.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 24'd1;
    bit_d     = bit_q;
    data_d    = data_q;
    par_bad_d = par_bad_q;
    frm_bad_d = frm_bad_q;
    push_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 24'd0;
        if (!rx_sync_q) begin
          state_d = ST_START;
          cnt_d   = 24'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q >= half_s) begin
          cnt_d = 24'd0;
          if (!rx_sync_q) begin
            state_d   = ST_DATA;
            bit_d     = 4'd0;
            data_d    = 9'd0;
            par_bad_d = 1'b0;
            frm_bad_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (cnt_q >= baud_m1_s) begin
          cnt_d          = 24'd0;
          data_d[bit_q]  = rx_sync_q;
          if (bit_q >= last_bit_s) begin
            state_d = (parity_s != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (cnt_q >= baud_m1_s) begin
          cnt_d   = 24'd0;
          state_d = ST_STOP;
          case (parity_s)
            PAR_EVEN: par_bad_d = (^data_q) ^ rx_sync_q;
            PAR_ODD:  par_bad_d = ~((^data_q) ^ rx_sync_q);
            default:  par_bad_d = 1'b0;
          endcase
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (cnt_q >= baud_m1_s) begin
          cnt_d     = 24'd0;
          state_d   = ST_IDLE;
          frm_bad_d = ~rx_sync_q;
          push_d    = 1'b1;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 24'd0;
      end
    endcase
    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = 24'd0;
      push_d  = 1'b0;
    end
  end

  // FIFO pointers, fill level, sticky error flags and rts.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      ovf_err_q <= 1'b0;
      rts_q     <= 1'b1;
    end else begin
      rts_q <= flow_s ? (free_s <= MARGIN_W) : 1'b0;
      if (clear) begin
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        count_q   <= '0;
        par_err_q <= 1'b0;
        frm_err_q <= 1'b0;
        ovf_err_q <= 1'b0;
      end else begin
        if (wr_en_s) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (rd_en_s) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        count_q <= count_q + {{STACK_ADDR_WIDTH{1'b0}}, wr_en_s}
                           - {{STACK_ADDR_WIDTH{1'b0}}, rd_en_s};
        if (push_q) begin
          par_err_q <= par_err_q | par_bad_q;
          frm_err_q <= frm_err_q | frm_bad_q;
          ovf_err_q <= ovf_err_q | full_s;
        end
      end
    end
  end

  // Word storage; contents are only observable through the pointers.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= data_q;
    end
  end

endmodule

// File: tb/tb_airi5c_uart_rx.sv
// Randomised and directed bench for airi5c_uart_rx against a frame-level
// reference model (queue of expected words plus sticky flag bits).
module tb_airi5c_uart_rx;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int MARGIN = 2;

  logic clk = 1'b0;
  logic n_reset, clear, rx, rts, pop;
  logic [31:0] ctrl_reg;
  logic [8:0]  data_out;
  logic [AW:0] size;
  logic empty, full, parity_error, frame_error, overflow_error;

  airi5c_uart_rx #(.STACK_ADDR_WIDTH(AW), .RTS_MARGIN(MARGIN)) dut (
    .clk(clk), .n_reset(n_reset), .clear(clear), .rx(rx), .rts(rts),
    .ctrl_reg(ctrl_reg), .pop(pop), .data_out(data_out), .size(size),
    .empty(empty), .full(full), .parity_error(parity_error),
    .frame_error(frame_error), .overflow_error(overflow_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_q[$];
  bit exp_par, exp_frm, exp_ovf;
  int cfg_nb, cfg_par, cfg_stp, cfg_fc, cfg_baud;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cfg(input int nb, input int par, input int stp, input int fc, input int baud);
    cfg_nb = nb; cfg_par = par; cfg_stp = stp; cfg_fc = fc; cfg_baud = baud;
    ctrl_reg = {3'(nb - 5), 2'(par), 2'(stp), 1'(fc), 24'(baud)};
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_par = 1'b0; exp_frm = 1'b0; exp_ovf = 1'b0;
  endtask

  // nsend > 0 sends only that many bit periods (aborted frame, model untouched).
  task automatic send_frame(input logic [8:0] d, input bit bad_par, input bit stop_low, input int nsend);
    logic [8:0] m;
    logic [8:0] mask;
    bit p;
    bit bq[$];
    int dq[$];
    mask = (9'h1 << cfg_nb) - 9'h1;
    if (cfg_nb == 9) mask = 9'h1FF;
    m = d & mask;
    bq.push_back(1'b0); dq.push_back(cfg_baud);
    for (int i = 0; i < cfg_nb; i++) begin
      bq.push_back(m[i]); dq.push_back(cfg_baud);
    end
    if (cfg_par != 0) begin
      p = ^m;
      if (cfg_par == 2) p = ~p;
      if (bad_par) p = ~p;
      bq.push_back(p); dq.push_back(cfg_baud);
    end
    bq.push_back(!stop_low); dq.push_back(cfg_baud);
    if (cfg_stp == 1) begin bq.push_back(1'b1); dq.push_back(cfg_baud / 2); end
    if (cfg_stp == 2) begin bq.push_back(1'b1); dq.push_back(cfg_baud); end
    for (int i = 0; i < bq.size(); i++) begin
      if (nsend > 0 && i >= nsend) break;
      rx = bq[i];
      repeat (dq[i]) @(negedge clk);
    end
    rx = 1'b1;
    if (nsend == 0) begin
      if (exp_q.size() == DEPTH) exp_ovf = 1'b1;
      else exp_q.push_back(m);
      if (bad_par && cfg_par != 0) exp_par = 1'b1;
      if (stop_low) exp_frm = 1'b1;
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, " size"}, 32'(size), 32'(exp_q.size()));
    check_eq({tag, " empty"}, 32'(empty), 32'(exp_q.size() == 0));
    check_eq({tag, " full"}, 32'(full), 32'(exp_q.size() == DEPTH));
    check_eq({tag, " parity_error"}, 32'(parity_error), 32'(exp_par));
    check_eq({tag, " frame_error"}, 32'(frame_error), 32'(exp_frm));
    check_eq({tag, " overflow_error"}, 32'(overflow_error), 32'(exp_ovf));
    check_eq({tag, " rts"}, 32'(rts), 32'(cfg_fc != 0 && (DEPTH - exp_q.size()) <= MARGIN));
    if (exp_q.size() > 0) check_eq({tag, " data_out"}, 32'(data_out), 32'(exp_q[0]));
  endtask

  task automatic do_pop();
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    wait_cycles(2);
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
    wait_cycles(2);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [8:0] d;
    bit bp, sl;
    n_reset = 1'b0; clear = 1'b0; rx = 1'b1; pop = 1'b0;
    model_reset();
    set_cfg(8, 0, 0, 0, 16);
    wait_cycles(3);
    check_eq("reset rts", 32'(rts), 32'd1);
    check_eq("reset empty", 32'(empty), 32'd1);
    check_eq("reset size", 32'(size), 32'd0);
    check_eq("reset flags", {29'd0, parity_error, frame_error, overflow_error}, 32'd0);
    n_reset = 1'b1;
    wait_cycles(4);
    check_state("idle");

    // 8N1 back-to-back frames
    send_frame(9'h055, 1'b0, 1'b0, 0);
    send_frame(9'h0A3, 1'b0, 1'b0, 0);
    wait_cycles(20);
    check_state("8n1 two");
    do_pop(); check_state("8n1 pop1");
    do_pop(); check_state("8n1 pop2");
    do_pop(); check_state("pop empty");

    // 9E2 with bad then good parity
    set_cfg(9, 1, 2, 0, 10);
    send_frame(9'h1FF, 1'b1, 1'b0, 0);
    wait_cycles(20);
    check_state("9e2 bad");
    clear_pulse();
    send_frame(9'h1FF, 1'b0, 1'b0, 0);
    wait_cycles(20);
    check_state("9e2 good");
    do_pop();

    // 5O1 and a short glitch on idle rx
    set_cfg(5, 2, 0, 0, 16);
    send_frame(9'h015, 1'b0, 1'b0, 0);
    wait_cycles(20);
    check_state("5o1");
    do_pop();
    rx = 1'b0; wait_cycles(4); rx = 1'b1;
    wait_cycles(40);
    check_state("glitch");

    // stop bit low
    set_cfg(8, 0, 0, 0, 16);
    send_frame(9'h03C, 1'b0, 1'b1, 0);
    wait_cycles(40);
    check_state("stop low");
    clear_pulse();
    check_state("after clear");

    // flow control and overflow
    set_cfg(8, 0, 0, 1, 16);
    for (int i = 0; i < 5; i++) begin
      send_frame(9'($urandom), 1'b0, 1'b0, 0);
      wait_cycles(40);
      check_state("flow");
    end
    while (exp_q.size() > 0) begin
      do_pop(); check_state("drain");
    end
    clear_pulse();

    // abort mid-DATA with clear, then with reset
    set_cfg(8, 0, 0, 0, 16);
    send_frame(9'h0A5, 1'b0, 1'b0, 4);
    clear_pulse();
    wait_cycles(40);
    check_state("abort clear");
    send_frame(9'h05A, 1'b0, 1'b0, 5);
    n_reset = 1'b0;
    wait_cycles(2);
    check_eq("abort reset rts", 32'(rts), 32'd1);
    check_eq("abort reset size", 32'(size), 32'd0);
    rx = 1'b1;
    n_reset = 1'b1;
    model_reset();
    wait_cycles(40);
    check_state("after reset");
    send_frame(9'h096, 1'b0, 1'b0, 0);
    wait_cycles(20);
    check_state("post reset frame");
    do_pop();

    // randomised frames against the model
    for (int it = 0; it < 30; it++) begin
      set_cfg($urandom_range(9, 5), $urandom_range(2, 0), $urandom_range(2, 0),
              $urandom_range(1, 0), $urandom_range(14, 4));
      wait_cycles(3);
      d  = 9'($urandom);
      bp = ($urandom % 5) == 0;
      sl = ($urandom % 6) == 0;
      send_frame(d, bp, sl, 0);
      wait_cycles(2 * cfg_baud + 6);
      check_state("rand");
      if (($urandom % 2) == 0 && exp_q.size() > 0) begin
        do_pop(); check_state("rand pop");
      end
      if (($urandom % 10) == 0) begin
        clear_pulse(); check_state("rand clear");
      end
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
